axi_mem_responder: RTL and testbench

- AXI4 slave (responder) serving the same reduced AXI subset that the merger kernels drive as masters: AW/W/B for writes, AR/R for reads, INCR bursts only.
- Backed by an on-chip byte-writable memory.
- Used as a self-contained memory endpoint for kernel-level simulation and on-chip loopback, in place of the platform memory controller.
- Serves one burst at a time and arbitrates read and write bursts round-robin.

---
 rtl/axi_mem_responder_pkg.sv | 23 ++
 rtl/axi_mem_responder_mem_sp_bytewe.sv | 33 +++
 rtl/axi_mem_responder.sv | 248 ++++++++++++++++++++++++
 tb/tb_axi_mem_responder.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_mem_responder_pkg.sv
// Shared types and constants for the AXI memory responder.
// Derives memory geometry from the bus width and memory depth.
package axi_mem_responder_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD      = 2'd1,
        WR_DATA = 2'd2,
        WR_RESP = 2'd3
    } state_t;

    // Nine bits so a 256-beat burst count never wraps back to zero
    localparam int CNT_W = 9;

    function automatic int log_dw_bytes(input int data_width);
        return $clog2(data_width / 8);
    endfunction

    function automatic int log_depth(input int mem_depth);
        return $clog2(mem_depth);
    endfunction

endpackage

// File: rtl/axi_mem_responder_mem_sp_bytewe.sv
// Single-port RAM with per-byte write enables and a registered read port.
// The read is read-first and the output holds whenever en is low.
module mem_sp_bytewe #(
    parameter int DATA_W = 512,
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10
) (
    input  logic                clk,
    input  logic                en,
    input  logic [DATA_W/8-1:0] we,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wdata,
    output logic [DATA_W-1:0]   rdata
);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [DATA_W-1:0] rdata_r;

    // Byte-masked write and registered read of the addressed word
    always_ff @(posedge clk) begin
        if (en) begin
            for (int b = 0; b < DATA_W / 8; b++) begin
                if (we[b]) begin
                    mem_r[addr][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
            rdata_r <= mem_r[addr];
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/axi_mem_responder.sv
// AXI4 INCR-only slave backed by a byte-writable on-chip RAM.
// Serves one burst at a time; read and write bursts alternate round-robin.
module axi_mem_responder
    import axi_mem_responder_pkg::*;
#(
    parameter int C_ID_WIDTH         = 1,
    parameter int C_M_AXI_ADDR_WIDTH = 64,
    parameter int C_M_AXI_DATA_WIDTH = 512,
    parameter int C_MEM_DEPTH        = 1024
) (
    input  logic                            aclk,
    input  logic                            areset,
    input  logic                            s_axi_awvalid,
    output logic                            s_axi_awready,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [7:0]                      s_axi_awlen,
    input  logic                            s_axi_wvalid,
    output logic                            s_axi_wready,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                            s_axi_wlast,
    output logic                            s_axi_bvalid,
    input  logic                            s_axi_bready,
    input  logic                            s_axi_arvalid,
    output logic                            s_axi_arready,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [7:0]                      s_axi_arlen,
    input  logic [2:0]                      s_axi_arsize,
    input  logic [C_ID_WIDTH-1:0]           s_axi_arid,
    output logic                            s_axi_rvalid,
    input  logic                            s_axi_rready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
    output logic                            s_axi_rlast,
    output logic [C_ID_WIDTH-1:0]           s_axi_rid,
    output logic                            protocol_err
);

    localparam int DW           = C_M_AXI_DATA_WIDTH;
    localparam int SW           = C_M_AXI_DATA_WIDTH / 8;
    localparam int LOG_DW_BYTES = log_dw_bytes(C_M_AXI_DATA_WIDTH);
    localparam int LOG_DEPTH    = log_depth(C_MEM_DEPTH);

    state_t                  state_r, state_s;
    logic                    rr_read_r;
    logic [LOG_DEPTH-1:0]    idx_r;
    logic [7:0]              len_r;
    logic [C_ID_WIDTH-1:0]   id_r;
    logic [CNT_W-1:0]        cnt_r;
    logic [CNT_W-1:0]        ocnt_r;
    logic                    m_vld_r;
    logic                    rvalid_r;
    logic [DW-1:0]           rdata_r;
    logic                    rlast_r;
    logic [C_ID_WIDTH-1:0]   rid_r;
    logic                    perr_r;

    logic                    arready_s, awready_s, wready_s, bvalid_s;
    logic                    ar_hs_s, aw_hs_s, w_hs_s, r_hs_s;
    logic                    out_ready_s, issue_s, last_wbeat_s;
    logic                    mem_en_s;
    logic [SW-1:0]           mem_we_s;
    logic [LOG_DEPTH-1:0]    mem_addr_s;
    logic [DW-1:0]           mem_rdata_s;
    logic                    unused_s;

    assign unused_s = ^{s_axi_arsize, s_axi_araddr, s_axi_awaddr};

    assign ar_hs_s      = s_axi_arvalid & arready_s;
    assign aw_hs_s      = s_axi_awvalid & awready_s;
    assign w_hs_s       = s_axi_wvalid & wready_s;
    assign r_hs_s       = rvalid_r & s_axi_rready;
    assign out_ready_s  = ~rvalid_r | s_axi_rready;
    assign last_wbeat_s = (cnt_r == {1'b0, len_r});

    // State register
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (ar_hs_s) begin
                    state_s = RD;
                end else if (aw_hs_s) begin
                    state_s = WR_DATA;
                end else begin
                    state_s = IDLE;
                end
            end
            RD: begin
                if (r_hs_s && rlast_r) begin
                    state_s = IDLE;
                end else begin
                    state_s = RD;
                end
            end
            WR_DATA: begin
                if (w_hs_s && last_wbeat_s) begin
                    state_s = WR_RESP;
                end else begin
                    state_s = WR_DATA;
                end
            end
            WR_RESP: begin
                if (s_axi_bready) begin
                    state_s = IDLE;
                end else begin
                    state_s = WR_RESP;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Channel handshake outputs; IDLE grants follow the round-robin pointer
    always_comb begin
        arready_s = 1'b0;
        awready_s = 1'b0;
        wready_s  = 1'b0;
        bvalid_s  = 1'b0;
        case (state_r)
            IDLE: begin
                arready_s = s_axi_arvalid & (~s_axi_awvalid | rr_read_r);
                awready_s = s_axi_awvalid & (~s_axi_arvalid | ~rr_read_r);
            end
            WR_DATA: wready_s = 1'b1;
            WR_RESP: bvalid_s = 1'b1;
            RD:      wready_s = 1'b0;
            default: wready_s = 1'b0;
        endcase
    end

    // RAM port control: a read may issue only if the RAM output stage has room
    always_comb begin
        issue_s = 1'b0;
        if ((state_r == RD) && (cnt_r <= {1'b0, len_r}) && (~m_vld_r || out_ready_s)) begin
            issue_s = 1'b1;
        end else begin
            issue_s = 1'b0;
        end
        mem_en_s = ar_hs_s | issue_s | w_hs_s;
        if (w_hs_s) begin
            mem_we_s = s_axi_wstrb;
        end else begin
            mem_we_s = {SW{1'b0}};
        end
        if (ar_hs_s) begin
            mem_addr_s = s_axi_araddr[LOG_DW_BYTES +: LOG_DEPTH];
        end else begin
            mem_addr_s = idx_r;
        end
    end

    // Burst bookkeeping, round-robin pointer and sticky protocol error
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            rr_read_r <= 1'b1;
            idx_r     <= {LOG_DEPTH{1'b0}};
            len_r     <= 8'd0;
            id_r      <= {C_ID_WIDTH{1'b0}};
            cnt_r     <= {CNT_W{1'b0}};
            perr_r    <= 1'b0;
        end else begin
            if (ar_hs_s) begin
                rr_read_r <= 1'b0;
                idx_r     <= s_axi_araddr[LOG_DW_BYTES +: LOG_DEPTH] + LOG_DEPTH'(1);
                len_r     <= s_axi_arlen;
                id_r      <= s_axi_arid;
                cnt_r     <= CNT_W'(1);
            end else if (aw_hs_s) begin
                rr_read_r <= 1'b1;
                idx_r     <= s_axi_awaddr[LOG_DW_BYTES +: LOG_DEPTH];
                len_r     <= s_axi_awlen;
                cnt_r     <= {CNT_W{1'b0}};
            end else if (issue_s || w_hs_s) begin
                idx_r <= idx_r + LOG_DEPTH'(1);
                cnt_r <= cnt_r + CNT_W'(1);
            end
            if (w_hs_s && (s_axi_wlast != last_wbeat_s)) begin
                perr_r <= 1'b1;
            end
        end
    end

    // Read pipeline: RAM output stage feeding the R output register
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            m_vld_r  <= 1'b0;
            rvalid_r <= 1'b0;
            rdata_r  <= {DW{1'b0}};
            rlast_r  <= 1'b0;
            rid_r    <= {C_ID_WIDTH{1'b0}};
            ocnt_r   <= {CNT_W{1'b0}};
        end else begin
            if (ar_hs_s || issue_s) begin
                m_vld_r <= 1'b1;
            end else if (out_ready_s) begin
                m_vld_r <= 1'b0;
            end
            if (ar_hs_s) begin
                ocnt_r <= {CNT_W{1'b0}};
            end else if (out_ready_s && m_vld_r) begin
                ocnt_r <= ocnt_r + CNT_W'(1);
            end
            if (out_ready_s) begin
                rvalid_r <= m_vld_r;
                if (m_vld_r) begin
                    rdata_r <= mem_rdata_s;
                    rlast_r <= (ocnt_r == {1'b0, len_r});
                    rid_r   <= id_r;
                end else begin
                    rlast_r <= 1'b0;
                end
            end
        end
    end

    mem_sp_bytewe #(
        .DATA_W (DW),
        .DEPTH  (C_MEM_DEPTH),
        .ADDR_W (LOG_DEPTH)
    ) u_mem (
        .clk   (aclk),
        .en    (mem_en_s),
        .we    (mem_we_s),
        .addr  (mem_addr_s),
        .wdata (s_axi_wdata),
        .rdata (mem_rdata_s)
    );

    assign s_axi_arready = arready_s;
    assign s_axi_awready = awready_s;
    assign s_axi_wready  = wready_s;
    assign s_axi_bvalid  = bvalid_s;
    assign s_axi_rvalid  = rvalid_r;
    assign s_axi_rdata   = rdata_r;
    assign s_axi_rlast   = rlast_r;
    assign s_axi_rid     = rid_r;
    assign protocol_err  = perr_r;

endmodule

// File: tb/tb_axi_mem_responder.sv
// Scoreboard bench for axi_mem_responder: a word-array model predicts read data,
// a negedge monitor collects R beats and channel statistics.
module tb_axi_mem_responder;

    localparam int DW    = 512;
    localparam int SW    = DW / 8;
    localparam int DEPTH = 1024;

    logic            aclk = 1'b0;
    logic            areset;
    logic            s_axi_awvalid, s_axi_awready;
    logic [63:0]     s_axi_awaddr;
    logic [7:0]      s_axi_awlen;
    logic            s_axi_wvalid, s_axi_wready;
    logic [DW-1:0]   s_axi_wdata;
    logic [SW-1:0]   s_axi_wstrb;
    logic            s_axi_wlast;
    logic            s_axi_bvalid, s_axi_bready;
    logic            s_axi_arvalid, s_axi_arready;
    logic [63:0]     s_axi_araddr;
    logic [7:0]      s_axi_arlen;
    logic [2:0]      s_axi_arsize;
    logic [0:0]      s_axi_arid;
    logic            s_axi_rvalid, s_axi_rready;
    logic [DW-1:0]   s_axi_rdata;
    logic            s_axi_rlast;
    logic [0:0]      s_axi_rid;
    logic            protocol_err;

    always #5 aclk = ~aclk;

    axi_mem_responder dut (
        .aclk(aclk), .areset(areset),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
        .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
        .s_axi_arsize(s_axi_arsize), .s_axi_arid(s_axi_arid),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .s_axi_rdata(s_axi_rdata), .s_axi_rlast(s_axi_rlast), .s_axi_rid(s_axi_rid),
        .protocol_err(protocol_err)
    );

    logic [DW-1:0] model [DEPTH];
    logic [DW-1:0] wdata_q [$];
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] got_data_q [$];
    logic          got_last_q [$];
    logic [0:0]    got_id_q [$];
    int            got_cyc_q [$];
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int both_ready_cnt = 0;
    int stab_err = 0;
    int b_cnt = 0;
    int ar_hs_cyc = 0;
    int first_rv_cyc = 0;
    logic rv_prev = 1'b0;
    logic stall_prev = 1'b0;
    logic [DW-1:0] held_data = '0;
    logic held_last = 1'b0;

    always @(posedge aclk) cyc <= cyc + 1;

    // Channel monitor sampled mid-cycle
    always @(negedge aclk) begin
        if (s_axi_arready && s_axi_awready) both_ready_cnt <= both_ready_cnt + 1;
        if (s_axi_arvalid && s_axi_arready) ar_hs_cyc <= cyc;
        if (s_axi_rvalid && !rv_prev) first_rv_cyc <= cyc;
        if (stall_prev && s_axi_rvalid && (s_axi_rdata !== held_data || s_axi_rlast !== held_last))
            stab_err <= stab_err + 1;
        if (s_axi_rvalid && s_axi_rready) begin
            got_data_q.push_back(s_axi_rdata);
            got_last_q.push_back(s_axi_rlast);
            got_id_q.push_back(s_axi_rid);
            got_cyc_q.push_back(cyc);
        end
        if (s_axi_bvalid && s_axi_bready) b_cnt <= b_cnt + 1;
        rv_prev    <= s_axi_rvalid;
        stall_prev <= s_axi_rvalid && !s_axi_rready;
        held_data  <= s_axi_rdata;
        held_last  <= s_axi_rlast;
    end

    initial begin
        #500000;
        $display("FAIL watchdog cycles=%0d limit reached", cyc);
        $fatal(1, "watchdog");
    end

    task automatic clear_q();
        exp_q.delete(); got_data_q.delete(); got_last_q.delete(); got_id_q.delete(); got_cyc_q.delete();
    endtask

    task automatic reset_dut();
        areset = 1'b1;
        s_axi_awvalid = 1'b0; s_axi_awaddr = 64'h0; s_axi_awlen = 8'd0;
        s_axi_wvalid = 1'b0; s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 1'b0;
        s_axi_arvalid = 1'b0; s_axi_araddr = 64'h0; s_axi_arlen = 8'd0;
        s_axi_arsize = 3'd6; s_axi_arid = 1'b0;
        s_axi_bready = 1'b1; s_axi_rready = 1'b1;
        repeat (3) @(posedge aclk);
        #1 areset = 1'b0;
    endtask

    task automatic do_write(input logic [63:0] addr, input logic [7:0] len, input logic [SW-1:0] strb,
                            input int last_at, output int bpulses);
        int guard;
        int b0;
        int idx;
        b0 = b_cnt;
        @(posedge aclk); #1;
        s_axi_awaddr = addr; s_axi_awlen = len; s_axi_awvalid = 1'b1;
        guard = 0;
        do begin @(negedge aclk); guard++; end while (!s_axi_awready && guard < 50);
        if (!s_axi_awready) begin checks++; failures++; $display("FAIL aw_wait got=timeout exp=awready"); end
        @(posedge aclk); #1 s_axi_awvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            s_axi_wvalid = 1'b1; s_axi_wdata = wdata_q[i]; s_axi_wstrb = strb; s_axi_wlast = (i == last_at);
            guard = 0;
            do begin @(negedge aclk); guard++; end while (!s_axi_wready && guard < 50);
            if (!s_axi_wready) begin checks++; failures++; $display("FAIL w_wait got=timeout exp=wready"); end
            idx = (int'(addr[15:6]) + i) % DEPTH;
            for (int b = 0; b < SW; b++)
                if (strb[b]) model[idx][b*8 +: 8] = wdata_q[i][b*8 +: 8];
            @(posedge aclk); #1;
        end
        s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
        repeat (6) @(posedge aclk);
        #1 bpulses = b_cnt - b0;
    endtask

    task automatic issue_ar(input logic [63:0] addr, input logic [7:0] len, input logic [0:0] id);
        int guard;
        @(posedge aclk); #1;
        s_axi_araddr = addr; s_axi_arlen = len; s_axi_arid = id; s_axi_arvalid = 1'b1;
        guard = 0;
        do begin @(negedge aclk); guard++; end while (!s_axi_arready && guard < 50);
        if (!s_axi_arready) begin checks++; failures++; $display("FAIL ar_wait got=timeout exp=arready"); end
        for (int i = 0; i <= int'(len); i++) exp_q.push_back(model[(int'(addr[15:6]) + i) % DEPTH]);
        @(posedge aclk); #1 s_axi_arvalid = 1'b0;
    endtask

    task automatic wait_beats(input int n);
        int guard = 0;
        while (got_data_q.size() < n && guard < 300) begin @(posedge aclk); guard++; end
        repeat (3) @(posedge aclk);
        #1;
        checks++;
        if (got_data_q.size() != n) begin
            failures++; $display("FAIL beat_count got=%0d exp=%0d", got_data_q.size(), n);
        end
    endtask

    task automatic test_reset();
        areset = 1'b1;
        #1;
        checks++;
        if ({s_axi_arready, s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_rvalid, s_axi_rlast, protocol_err} !== 7'b0) begin
            failures++; $display("FAIL reset_ctrl got=%b exp=0000000",
                {s_axi_arready, s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_rvalid, s_axi_rlast, protocol_err});
        end
        checks++;
        if (s_axi_rdata !== '0 || s_axi_rid !== 1'b0) begin
            failures++; $display("FAIL reset_rdata got=%h rid=%b exp=0", s_axi_rdata[31:0], s_axi_rid);
        end
        reset_dut();
    endtask

    task automatic test_write_read();
        int bp;
        clear_q(); wdata_q.delete();
        for (int i = 0; i < 16; i++) wdata_q.push_back(DW'(i));
        do_write(64'h0, 8'd15, {SW{1'b1}}, 15, bp);
        checks++; if (bp != 1) begin failures++; $display("FAIL wr_bvalid_pulses got=%0d exp=1", bp); end
        checks++; if (protocol_err !== 1'b0) begin failures++; $display("FAIL wr_perr got=%b exp=0", protocol_err); end
        issue_ar(64'h0, 8'd15, 1'b1);
        wait_beats(16);
        checks++;
        if (first_rv_cyc - ar_hs_cyc != 2) begin
            failures++; $display("FAIL rd_latency got=%0d exp=2", first_rv_cyc - ar_hs_cyc);
        end
        if (got_cyc_q.size() == 16) begin
            checks++;
            if (got_cyc_q[15] - got_cyc_q[0] != 15) begin
                failures++; $display("FAIL rd_streaming got=%0d exp=15", got_cyc_q[15] - got_cyc_q[0]);
            end
        end
        for (int i = 0; i < 16 && got_data_q.size() > 0; i++) begin
            logic [DW-1:0] e, g;
            logic gl;
            logic [0:0] gi;
            e = exp_q.pop_front(); g = got_data_q.pop_front(); gl = got_last_q.pop_front(); gi = got_id_q.pop_front();
            checks++;
            if ({g, gl, gi} !== {e, (i == 15), 1'b1}) begin
                failures++; $display("FAIL wr_rd_beat%0d got=%h/%b/%b exp=%h/%b/1", i, g[31:0], gl, gi, e[31:0], (i == 15));
            end
        end
    endtask

    task automatic test_partial_strobe();
        int bp;
        int zeros;
        logic [DW-1:0] e, g;
        clear_q();
        wdata_q.delete(); wdata_q.push_back({DW{1'b1}});
        do_write(64'(3 * 64), 8'd0, {SW{1'b1}}, 0, bp);
        wdata_q.delete(); wdata_q.push_back({DW{1'b0}});
        do_write(64'(3 * 64), 8'd0, 64'h000F_0000_0000_000F, 0, bp);
        issue_ar(64'(3 * 64), 8'd0, 1'b0);
        wait_beats(1);
        if (got_data_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_data_q.pop_front();
            checks++;
            if (g !== e) begin failures++; $display("FAIL strobe_word got=%h exp=%h", g[447:384], e[447:384]); end
            zeros = 0;
            for (int b = 0; b < SW; b++) if (g[b*8 +: 8] == 8'h00) zeros++;
            checks++;
            if (zeros != 8 || g[7:0] !== 8'h00 || g[415:408] !== 8'h00 || g[39:32] !== 8'hFF) begin
                failures++; $display("FAIL strobe_bytes got=%0d zero bytes exp=8", zeros);
            end
        end
    endtask

    task automatic test_arbitration();
        int guard;
        reset_dut(); clear_q();
        @(posedge aclk); #1;
        s_axi_araddr = 64'h0; s_axi_arlen = 8'd0; s_axi_arid = 1'b0; s_axi_arvalid = 1'b1;
        s_axi_awaddr = 64'(5 * 64); s_axi_awlen = 8'd0; s_axi_awvalid = 1'b1;
        @(negedge aclk);
        checks++;
        if ({s_axi_arready, s_axi_awready} !== 2'b10) begin
            failures++; $display("FAIL arb_first got=%b exp=10", {s_axi_arready, s_axi_awready});
        end
        exp_q.push_back(model[0]);
        @(posedge aclk); #1 s_axi_araddr = 64'(64);
        guard = 0;
        do begin @(negedge aclk); guard++; end while (!s_axi_arready && !s_axi_awready && guard < 50);
        checks++;
        if ({s_axi_arready, s_axi_awready} !== 2'b01) begin
            failures++; $display("FAIL arb_second got=%b exp=01", {s_axi_arready, s_axi_awready});
        end
        @(posedge aclk); #1 s_axi_awvalid = 1'b0;
        s_axi_wvalid = 1'b1; s_axi_wdata = DW'(32'h5555); s_axi_wstrb = {SW{1'b1}}; s_axi_wlast = 1'b1;
        guard = 0;
        do begin @(negedge aclk); guard++; end while (!s_axi_wready && guard < 50);
        model[5] = DW'(32'h5555);
        @(posedge aclk); #1 s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
        guard = 0;
        do begin @(negedge aclk); guard++; end while (!s_axi_arready && guard < 50);
        exp_q.push_back(model[1]);
        @(posedge aclk); #1 s_axi_arvalid = 1'b0;
        wait_beats(2);
        for (int i = 0; i < 2 && got_data_q.size() > 0; i++) begin
            logic [DW-1:0] e, g;
            e = exp_q.pop_front(); g = got_data_q.pop_front();
            checks++;
            if (g !== e) begin failures++; $display("FAIL arb_rd%0d got=%h exp=%h", i, g[31:0], e[31:0]); end
        end
        checks++;
        if (both_ready_cnt != 0) begin failures++; $display("FAIL arb_both_ready got=%0d exp=0", both_ready_cnt); end
    endtask

    task automatic test_stall();
        int pat [4] = '{1, 0, 0, 1};
        int k = 0;
        clear_q();
        issue_ar(64'(8 * 64), 8'd7, 1'b1);
        while (got_data_q.size() < 8 && k < 200) begin
            s_axi_rready = pat[k % 4][0];
            @(posedge aclk); #1;
            k++;
        end
        s_axi_rready = 1'b1;
        wait_beats(8);
        for (int i = 0; i < 8 && got_data_q.size() > 0; i++) begin
            logic [DW-1:0] e, g;
            logic gl;
            e = exp_q.pop_front(); g = got_data_q.pop_front(); gl = got_last_q.pop_front();
            checks++;
            if ({g, gl} !== {e, (i == 7)}) begin
                failures++; $display("FAIL stall_beat%0d got=%h/%b exp=%h/%b", i, g[31:0], gl, e[31:0], (i == 7));
            end
        end
        checks++;
        if (stab_err != 0) begin failures++; $display("FAIL stall_stable got=%0d changes exp=0", stab_err); end
    endtask

    task automatic test_wrap();
        int bp;
        logic [DW-1:0] g;
        clear_q(); wdata_q.delete();
        for (int i = 0; i < 4; i++) wdata_q.push_back(DW'(32'hA000_0000 + i));
        do_write(64'((DEPTH - 2) * 64), 8'd3, {SW{1'b1}}, 3, bp);
        issue_ar(64'h0, 8'd1, 1'b0);
        wait_beats(2);
        for (int i = 0; i < 2 && got_data_q.size() > 0; i++) begin
            g = got_data_q.pop_front();
            checks++;
            if (g !== DW'(32'hA000_0002 + i) || g !== exp_q.pop_front()) begin
                failures++; $display("FAIL wrap_word%0d got=%h exp=%h", i, g[31:0], 32'hA000_0002 + i);
            end
        end
    endtask

    task automatic test_protocol_err();
        int bp;
        clear_q(); wdata_q.delete();
        for (int i = 0; i < 6; i++) wdata_q.push_back(DW'(32'hC000_0000 + i));
        do_write(64'(20 * 64), 8'd5, {SW{1'b1}}, 2, bp);
        checks++; if (bp != 1) begin failures++; $display("FAIL perr_bvalid got=%0d exp=1", bp); end
        checks++; if (protocol_err !== 1'b1) begin failures++; $display("FAIL perr_set got=%b exp=1", protocol_err); end
        issue_ar(64'(20 * 64), 8'd5, 1'b0);
        wait_beats(6);
        for (int i = 0; i < 6 && got_data_q.size() > 0; i++) begin
            logic [DW-1:0] e, g;
            e = exp_q.pop_front(); g = got_data_q.pop_front();
            checks++;
            if (g !== e) begin failures++; $display("FAIL perr_beat%0d got=%h exp=%h", i, g[31:0], e[31:0]); end
        end
        checks++; if (protocol_err !== 1'b1) begin failures++; $display("FAIL perr_sticky got=%b exp=1", protocol_err); end
    endtask

    task automatic test_reset_mid_read();
        int guard = 0;
        clear_q();
        issue_ar(64'h0, 8'd15, 1'b0);
        while (got_data_q.size() < 3 && guard < 50) begin @(posedge aclk); guard++; end
        #1 areset = 1'b1;
        #1;
        checks++;
        if ({s_axi_rvalid, s_axi_bvalid, s_axi_wready, protocol_err} !== 4'b0) begin
            failures++; $display("FAIL rst_mid got=%b exp=0000", {s_axi_rvalid, s_axi_bvalid, s_axi_wready, protocol_err});
        end
        repeat (2) @(posedge aclk);
        #1 areset = 1'b0;
        clear_q();
        repeat (5) @(posedge aclk);
        #1;
        checks++;
        if (got_data_q.size() != 0) begin failures++; $display("FAIL rst_no_beats got=%0d exp=0", got_data_q.size()); end
        issue_ar(64'(20 * 64), 8'd3, 1'b1);
        wait_beats(4);
        for (int i = 0; i < 4 && got_data_q.size() > 0; i++) begin
            logic [DW-1:0] e, g;
            e = exp_q.pop_front(); g = got_data_q.pop_front();
            checks++;
            if (g !== e) begin failures++; $display("FAIL rst_reread%0d got=%h exp=%h", i, g[31:0], e[31:0]); end
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        test_reset();
        test_write_read();
        test_partial_strobe();
        test_arbitration();
        test_stall();
        test_wrap();
        test_protocol_err();
        test_reset_mid_read();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
